// File: rtl/at_command_sender.sv
// AT command sender: streams a ROM-selected AT command plus CR LF to a UART transmitter byte by byte.
// Optional tx_busy watchdog with sticky error flag is enabled by defining TX_TIMEOUT_EN.
module at_command_sender #(
  parameter int          CLK_DIV_UNUSED = 0,
  parameter int          MAX_LEN        = 12,
  parameter logic [23:0] TIMEOUT        = 24'd5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] command,
  input  logic       start,
  output logic       ready_command,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       error
);

  localparam int IW = $clog2(MAX_LEN + 2);
  localparam int SW = 8 * MAX_LEN;

  typedef logic [SW-1:0] str_t;

  // Strings are right-justified: the last character sits in the low byte.
  localparam str_t S_AT   = SW'("AT");
  localparam str_t S_ATE0 = SW'("ATE0");
  localparam str_t S_CMGF = SW'("AT+CMGF=1");
  localparam str_t S_CNMI = SW'("AT+CNMI=2,2");

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    NEXT      = 3'd5
  } state_t;

  state_t        state;
  logic [2:0]    cmd_r;
  logic [2:0]    last_cmd;
  logic          start_d;
  logic [IW-1:0] idx;
  logic          launch;

  function automatic logic [IW-1:0] cmd_len(input logic [2:0] c);
    case (c)
      3'd1:    cmd_len = IW'(4);
      3'd2:    cmd_len = IW'(9);
      3'd3:    cmd_len = IW'(11);
      default: cmd_len = IW'(2);
    endcase
  endfunction

  function automatic logic [7:0] rom_byte(input logic [2:0] c, input logic [IW-1:0] i);
    str_t s;
    int   len;
    int   k;
    case (c)
      3'd1:    s = S_ATE0;
      3'd2:    s = S_CMGF;
      3'd3:    s = S_CNMI;
      default: s = S_AT;
    endcase
    len = int'(cmd_len(c));
    k   = int'(i);
    if (k < len)       rom_byte = s[8*(len-1-k) +: 8];
    else if (k == len) rom_byte = 8'h0D;
    else               rom_byte = 8'h0A;
  endfunction

  // A held start re-launches only when the command index changes.
  assign launch = start && (!start_d || (command != last_cmd));

  if (CLK_DIV_UNUSED != 0) begin : g_reserved
  end

`ifdef TX_TIMEOUT_EN
  logic [23:0] timer;
`else
  if (TIMEOUT == 24'd0) begin : g_no_watchdog
  end
  assign error = 1'b0;
`endif

  // NOTE: all state and outputs below are registers, so every assignment is non-blocking (<=).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cmd_r         <= 3'h0;
      last_cmd      <= 3'h7;
      start_d       <= 1'b0;
      idx           <= '0;
      ready_command <= 1'b1;
      busy          <= 1'b0;
      tx_data       <= 8'h00;
      tx_start      <= 1'b0;
`ifdef TX_TIMEOUT_EN
      timer         <= '0;
      error         <= 1'b0;
`endif
    end else begin
      start_d  <= start;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            cmd_r         <= command;
            last_cmd      <= command;
            idx           <= '0;
            ready_command <= 1'b0;
            busy          <= 1'b1;
`ifdef TX_TIMEOUT_EN
            error         <= 1'b0;
`endif
            state         <= LOAD;
          end
        end
        LOAD: begin
          tx_data <= rom_byte(cmd_r, idx);
          state   <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
`ifdef TX_TIMEOUT_EN
            timer    <= TIMEOUT;
`endif
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK, WAIT_DONE: begin
          if ((state == WAIT_ACK) && tx_busy) begin
`ifdef TX_TIMEOUT_EN
            timer <= TIMEOUT;
`endif
            state <= WAIT_DONE;
          end else if ((state == WAIT_DONE) && !tx_busy) begin
            state <= NEXT;
`ifdef TX_TIMEOUT_EN
          end else if (timer == 24'd1) begin
            ready_command <= 1'b1;
            busy          <= 1'b0;
            error         <= 1'b1;
            state         <= IDLE;
          end else begin
            timer <= timer - 24'd1;
`endif
          end
        end
        NEXT: begin
          if (idx == cmd_len(cmd_r) + IW'(1)) begin
            ready_command <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            idx   <= idx + IW'(1);
            state <= LOAD;
          end
        end
        // NOTE: unused encodings recover to IDLE with the reset output values.
        default: begin
          state         <= IDLE;
          ready_command <= 1'b1;
          busy          <= 1'b0;
          tx_data       <= 8'h00;
          tx_start      <= 1'b0;
`ifdef TX_TIMEOUT_EN
          error         <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_at_command_sender.sv
// Self-checking bench for at_command_sender: UART model plus a byte scoreboard.
// The watchdog scenario runs only when TX_TIMEOUT_EN is defined.
module tb_at_command_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] command;
  logic       start;
  logic       ready_command;
  logic       busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       error;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         tx_total   = 0;
  int         uart_cnt   = 0;
  logic       force_busy = 1'b0;
  logic       stuck_en   = 1'b0;
  logic       stuck_hold = 1'b0;
  logic       prev_start = 1'b0;

  string cmd_str[8] = '{"AT", "ATE0", "AT+CMGF=1", "AT+CNMI=2,2", "AT", "AT", "AT", "AT"};

  at_command_sender #(
    .CLK_DIV_UNUSED(0),
    .MAX_LEN       (12),
    .TIMEOUT       (24'd100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .command      (command),
    .start        (start),
    .ready_command(ready_command),
    .busy         (busy),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_cmd(input int c);
    for (int i = 0; i < cmd_str[c].len(); i++) exp_q.push_back(cmd_str[c][i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Counts negedges with ready_command low until it returns high.
  task automatic wait_ready(input int budget, output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (ready_command) break;
      cycles++;
      if (cycles >= budget) begin
        check("ready_timeout", 32'(cycles), 32'(budget) - 1);
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // UART model and scoreboard: all driving and sampling on the falling edge.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        check("tx_start_pulse", 32'(prev_start), 32'd0);
        if (exp_q.size() == 0) check("unexpected_tx", 32'(tx_data), 32'hFFFF);
        else                   check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        tx_total++;
        uart_cnt = 10;
        if (stuck_en) stuck_hold = 1'b1;
      end
      prev_start = tx_start;
      tx_busy = force_busy | stuck_hold | (uart_cnt != 0);
      if (uart_cnt != 0) uart_cnt--;
      if (rst) check("busy_vs_ready", 32'(busy), 32'(!ready_command));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int cyc;
    int tx_before;
    rst = 1'b0; start = 1'b0; command = 3'd0;
    idle_cycles(3);
    check("rst_ready", 32'(ready_command), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_error", 32'(error), 32'd0);
    rst = 1'b1;
    idle_cycles(2);

    // Command 0 with a 10-cycle UART frame: 14 cycles per byte.
    push_cmd(0); command = 3'd0; start = 1'b1;
    wait_ready(2000, cyc);
    check("cmd0_latency", 32'(cyc), 32'd56);
    check("cmd0_drained", 32'(exp_q.size()), 32'd0);

    // Command change with start held launches straight from IDLE.
    push_cmd(3); command = 3'd3;
    wait_ready(2000, cyc);
    check("cmd3_latency", 32'(cyc), 32'd182);
    check("cmd3_drained", 32'(exp_q.size()), 32'd0);
    tx_before = tx_total;
    idle_cycles(1000);
    check("held_no_resend", 32'(tx_total), 32'(tx_before));
    check("held_ready", 32'(ready_command), 32'd1);

    // UART busy before launch stalls the first byte in SEND.
    force_busy = 1'b1; idle_cycles(1);
    push_cmd(1); command = 3'd1;
    tx_before = tx_total;
    idle_cycles(30);
    check("stall_no_tx", 32'(tx_total), 32'(tx_before));
    check("stall_tx_data", 32'(tx_data), 32'h41);
    check("stall_ready", 32'(ready_command), 32'd0);
    force_busy = 1'b0;
    wait_ready(2000, cyc);
    check("cmd1_drained", 32'(exp_q.size()), 32'd0);

    // Reset after the second byte of command 2, then a full resend.
    start = 1'b0; idle_cycles(2);
    push_cmd(2); command = 3'd2; start = 1'b1;
    tx_before = tx_total;
    cyc = 0;
    while (tx_total < tx_before + 2 && cyc < 200) begin
      idle_cycles(1);
      cyc++;
    end
    check("two_bytes_seen", 32'(tx_total - tx_before), 32'd2);
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(ready_command), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    exp_q.delete();
    idle_cycles(3);
    rst = 1'b1;
    push_cmd(2);
    idle_cycles(1);
    check("resend_launch", 32'(ready_command), 32'd0);
    wait_ready(3000, cyc);
    check("cmd2_drained", 32'(exp_q.size()), 32'd0);

    // Two start pulses with the same command send it twice.
    for (int p = 0; p < 2; p++) begin
      start = 1'b0; idle_cycles(2);
      push_cmd(4); command = 3'd4; start = 1'b1;
      wait_ready(2000, cyc);
      check("cmd4_latency", 32'(cyc), 32'd56);
      check("cmd4_drained", 32'(exp_q.size()), 32'd0);
    end

`ifdef TX_TIMEOUT_EN
    // tx_busy stuck after the first tx_start: watchdog aborts with error.
    start = 1'b0; idle_cycles(2);
    stuck_en = 1'b1;
    exp_q.push_back(8'h41);
    command = 3'd0; start = 1'b1;
    tx_before = tx_total;
    cyc = 0;
    while (tx_total == tx_before && cyc < 50) begin
      idle_cycles(1);
      cyc++;
    end
    wait_ready(500, cyc);
    check("wdog_window", 32'(cyc >= 98 && cyc <= 103), 32'd1);
    check("wdog_error", 32'(error), 32'd1);
    check("wdog_ready", 32'(ready_command), 32'd1);
    stuck_en = 1'b0; stuck_hold = 1'b0;
    idle_cycles(2);
    start = 1'b0; idle_cycles(2);
    push_cmd(0); start = 1'b1;
    idle_cycles(1);
    check("wdog_clear", 32'(error), 32'd0);
    wait_ready(2000, cyc);
    check("wdog_drained", 32'(exp_q.size()), 32'd0);
`endif

    check("final_error", 32'(error), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/at_command_sender.md
Name: at_command_sender

Overview:
- Downstream stage of the communications control FSM.
- Receives a 3-bit command index plus a start level and transmits the matching AT command string, terminated by CR LF, byte by byte to the UART transmitter.
- Reports completion on ready_command: high when idle, low while sending.
- Exports busy for the communications busy line.

Parameters:
- CLK_DIV_UNUSED, 0, reserved; no function, tie at default.
- MAX_LEN, 12, maximum command string length in bytes, excluding CR LF.
- TIMEOUT, 24'd5000000, cycles tx_busy may stay high before abort. Used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- command  input  3  command index; sampled at launch.
- start  input  1  level request from the controller; may stay high across several commands.
- ready_command  output  1  1 = idle/done, 0 = sending.
- busy  output  1  1 from launch until ready_command returns high.
- tx_data  output  8  byte to the UART; held stable during the byte handshake.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_busy  input  1  UART busy flag.
- error  output  1  sticky abort flag; only driven with the optional feature, otherwise tied 0.

Behaviour:
- Reset values: ready_command=1, busy=0, tx_start=0, tx_data=8'h00, error=0. Internal values: state=IDLE, last_cmd=3'h7, start_d=0, byte index=0.
- Reset mid-operation: immediate return to the reset values. The UART may still finish its current byte; the block ignores it.
- Command ROM (ASCII), exact contents:
  - 0 = "AT"
  - 1 = "ATE0"
  - 2 = "AT+CMGF=1"
  - 3 = "AT+CNMI=2,2"
  - 4..7 = "AT"
  - Length comes from the ROM; every command is followed by 8'h0D then 8'h0A.
- Launch condition, evaluated in IDLE: start==1 and (start_d==0 or command!=last_cmd).
  - start_d is start registered every cycle.
  - start held high with an unchanged command never resends.
  - start low then high resends the same command.
- On launch in cycle N: latch command into cmd_r and last_cmd, index=0, ready_command=0 and busy=1 from cycle N+1, go to LOAD.
- LOAD: tx_data = current byte (string byte, then 0D, then 0A); go to SEND.
- SEND: if tx_busy==0, pulse tx_start for one cycle and go to WAIT_ACK; otherwise stay in SEND.
- WAIT_ACK: wait for tx_busy==1, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy==0, then go to NEXT.
- NEXT:
  - If the byte just sent was 0A: ready_command=1, busy=0 next cycle, return to IDLE.
  - Otherwise: increment index and go to LOAD.
- Per-byte overhead: 4 cycles plus the UART frame time.
- command changing while sending is ignored. If it differs from last_cmd on return to IDLE, it launches immediately (no idle-cycle requirement).
- start dropping mid-send does not abort; the command completes.
- last_cmd resets to 7 so the first request always launches.
- Invalid state encodings go to IDLE with the reset output values.

Optional Feature:
- Macro TX_TIMEOUT_EN.
- Defined:
  - A 24-bit watchdog loads TIMEOUT on entry to WAIT_ACK or WAIT_DONE and decrements each cycle in those states.
  - On reaching 0: go to IDLE, ready_command=1, busy=0, error=1.
  - error stays set until the next launch, which clears it.
  - last_cmd keeps the aborted command.
- Undefined: no watchdog; the block waits indefinitely; error is constant 0.

Test Plan:
- rst released, command=0, start=1, UART model busy for 10 cycles per byte -> tx_start pulses carrying 41,54,0D,0A in order; ready_command low from launch+1 until 1 cycle after the last busy falls; busy is the complement.
- start held at 1, command changes 0->3 after ready returns -> 13 bytes "AT+CNMI=2,2"0D0A sent; then start held with command=3 for 1000 cycles -> no further tx_start.
- tx_busy forced high before launch with command=1 -> tx_start stays 0 and tx_data=41 held until tx_busy falls, then 41,54,45,30,0D,0A.
- rst asserted after the 2nd byte of command 2 -> within the reset cycle ready_command=1, busy=0, tx_start=0; after release with start=1, command=2 -> full resend starting at 41.
- TX_TIMEOUT_EN, TIMEOUT=100, tx_busy stuck high after first tx_start -> exactly 100 cycles later error=1, ready_command=1; next launch clears error.
- start pulsed 0->1 twice with command=4 -> "AT"0D0A sent twice.
